// File: rtl/forward_kin_if.sv
`default_nettype none
// ============================================================================
// Module      : forward_kin_if
// Description : Request/response bundle for the forward-kinematics block.
//               Master issues joint angles, slave returns the end-effector
//               position with a busy/valid handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface forward_kin_if;
    logic               start;
    logic signed [31:0] xita1;
    logic signed [31:0] xita2;
    logic               busy;
    logic               valid;
    logic signed [31:0] x;
    logic signed [31:0] y;

    modport master (
        output start, xita1, xita2,
        input  busy, valid, x, y
    );

    modport slave (
        input  start, xita1, xita2,
        output busy, valid, x, y
    );
endinterface
`default_nettype wire

// File: rtl/forward_kin.sv
`default_nettype none
// ============================================================================
// Module      : forward_kin
// Description : Two-link planar arm forward kinematics. One iterative
//               rotation-mode CORDIC engine is run twice per request: link 1
//               at xita1, link 2 at the wrapped sum xita1+xita2. The two
//               vectors are summed to give (x, y) in Q16.16 centimetres.
// Revision    : 1.0 - initial release
// ============================================================================
module forward_kin #(
    parameter logic signed [31:0] L1   = 32'h0007_6666,
    parameter logic signed [31:0] L2   = 32'h0012_0000,
    parameter int                 ITER = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    forward_kin_if.slave  bus
);

    localparam logic signed [32:0] PI     = 33'sd205887;
    localparam logic signed [31:0] HPI    = 32'sd102944;
    localparam logic signed [32:0] TWO_PI = 33'sd411775;
    localparam longint             K      = 39797;

    // Link lengths pre-scaled by the CORDIC gain so the engine output is
    // already the true link vector.
    localparam longint             LK1_W = (longint'(L1) * K) >>> 16;
    localparam longint             LK2_W = (longint'(L2) * K) >>> 16;
    localparam logic signed [31:0] LK1   = LK1_W[31:0];
    localparam logic signed [31:0] LK2   = LK2_W[31:0];
    localparam logic [3:0]         LAST  = 4'(ITER - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE1  = 3'd1,
        ITER1 = 3'd2,
        PRE2  = 3'd3,
        ITER2 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state;
    logic signed [31:0] a1, a2;
    logic signed [31:0] cx, cy, cz;
    logic signed [31:0] cx1, sy1;
    logic [3:0]         i;

    logic signed [32:0] sum33, wrap33;
    logic signed [31:0] pre_angle, pre_len;
    logic signed [31:0] px, py, pz;
    logic signed [31:0] xs, ys, at;
    logic signed [31:0] nx, ny, nz;

    function automatic logic signed [31:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 32'sd51472;
            4'd1:    atan_lut = 32'sd30386;
            4'd2:    atan_lut = 32'sd16055;
            4'd3:    atan_lut = 32'sd8150;
            4'd4:    atan_lut = 32'sd4091;
            4'd5:    atan_lut = 32'sd2047;
            4'd6:    atan_lut = 32'sd1024;
            4'd7:    atan_lut = 32'sd512;
            4'd8:    atan_lut = 32'sd256;
            4'd9:    atan_lut = 32'sd128;
            4'd10:   atan_lut = 32'sd64;
            4'd11:   atan_lut = 32'sd32;
            4'd12:   atan_lut = 32'sd16;
            4'd13:   atan_lut = 32'sd8;
            4'd14:   atan_lut = 32'sd4;
            default: atan_lut = 32'sd2;
        endcase
    endfunction

    // Absolute link-2 angle, wrapped back into [-pi, pi] via a 33-bit sum.
    always_comb begin
        sum33  = {bus.xita1[31], bus.xita1} + {bus.xita2[31], bus.xita2};
        wrap33 = sum33;
        if (sum33 > PI)
            wrap33 = sum33 - TWO_PI;
        else if (sum33 < -PI)
            wrap33 = sum33 + TWO_PI;
    end

    // Pre-rotation by +/-90 degrees brings the residual angle into the
    // CORDIC convergence range.
    always_comb begin
        pre_angle = (state == PRE1) ? a1  : a2;
        pre_len   = (state == PRE1) ? LK1 : LK2;
        px        = pre_len;
        py        = '0;
        pz        = pre_angle;
        if (pre_angle > HPI) begin
            px = '0;
            py = pre_len;
            pz = pre_angle - HPI;
        end else if (pre_angle < -HPI) begin
            px = '0;
            py = -pre_len;
            pz = pre_angle + HPI;
        end
    end

    // One CORDIC micro-rotation, direction chosen by the sign of z.
    always_comb begin
        xs = cx >>> i;
        ys = cy >>> i;
        at = atan_lut(i);
        if (!cz[31]) begin
            nx = cx - ys;
            ny = cy + xs;
            nz = cz - at;
        end else begin
            nx = cx + ys;
            ny = cy - xs;
            nz = cz + at;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a1        <= '0;
            a2        <= '0;
            cx        <= '0;
            cy        <= '0;
            cz        <= '0;
            cx1       <= '0;
            sy1       <= '0;
            i         <= '0;
            bus.busy  <= 1'b0;
            bus.valid <= 1'b0;
            bus.x     <= '0;
            bus.y     <= '0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a1       <= bus.xita1;
                        a2       <= wrap33[31:0];
                        bus.busy <= 1'b1;
                        state    <= PRE1;
                    end
                end
                PRE1, PRE2: begin
                    cx    <= px;
                    cy    <= py;
                    cz    <= pz;
                    i     <= '0;
                    state <= (state == PRE1) ? ITER1 : ITER2;
                end
                ITER1, ITER2: begin
                    cx <= nx;
                    cy <= ny;
                    cz <= nz;
                    i  <= i + 4'd1;
                    if (i == LAST) begin
                        if (state == ITER1) begin
                            cx1   <= nx;
                            sy1   <= ny;
                            state <= PRE2;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus.x     <= cx1 + cx;
                    bus.y     <= sy1 + cy;
                    bus.valid <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_forward_kin.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_kin
// Description : Self-checking bench for forward_kin. Expected positions come
//               from real-valued trigonometry of the two-link arm; round-trip
//               points use an analytic inverse-kinematics solution.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_kin;

    localparam int  PI  = 205887;
    localparam int  HPI = 102944;
    localparam real L1R = 484966.0;
    localparam real L2R = 1179648.0;

    logic clk = 1'b0;
    logic rst_n;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    forward_kin_if bus ();

    forward_kin dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    // Reference arm model: sum of two link vectors in Q16.16 LSB units.
    task automatic fk(input int a1, input int a2, output int ex, output int ey);
        real t1, t12;
        t1  = $itor(a1) / 65536.0;
        t12 = $itor(a1 + a2) / 65536.0;
        ex  = rnd(L1R * $cos(t1) + L2R * $cos(t12));
        ey  = rnd(L1R * $sin(t1) + L2R * $sin(t12));
    endtask

    // Analytic inverse kinematics (elbow-up branch) for round-trip points.
    task automatic ik(input int px, input int py, output int a1, output int a2);
        real r2, c2, t2, t1;
        r2 = $itor(px) * $itor(px) + $itor(py) * $itor(py);
        c2 = (r2 - L1R * L1R - L2R * L2R) / (2.0 * L1R * L2R);
        if (c2 > 1.0)  c2 = 1.0;
        if (c2 < -1.0) c2 = -1.0;
        t2 = $acos(c2);
        t1 = $atan2($itor(py), $itor(px)) - $atan2(L2R * $sin(t2), L1R + L2R * $cos(t2));
        a1 = rnd(t1 * 65536.0);
        a2 = rnd(t2 * 65536.0);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        longint diff;
        logic   ok;
        diff = longint'(obs) - longint'(exp);
        ok   = (diff <= tol) && (diff >= -tol);
        tests++;
        assert (ok === 1'b1) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic issue(input int a1, input int a2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.xita1 = a1;
        bus.xita2 = a2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int n, output logic busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.valid && !bus.busy) busy_ok = 1'b0;
        end while (!bus.valid && n < 100);
    endtask

    task automatic run(input string tag, input int a1, input int a2,
                       input int ex, input int ey, input int tol);
        int   n;
        logic bok;
        issue(a1, a2);
        wait_valid(n, bok);
        check_eq({tag, "_latency"}, n, 35);
        check_eq({tag, "_busy"}, bok, 1'b1);
        check_eq({tag, "_busy_drop"}, bus.busy, 1'b0);
        check_tol({tag, "_x"}, bus.x, ex, tol);
        check_tol({tag, "_y"}, bus.y, ey, tol);
    endtask

    task automatic run_model(input string tag, input int a1, input int a2);
        int ex, ey;
        fk(a1, a2, ex, ey);
        run(tag, a1, a2, ex, ey, 64);
    endtask

    initial begin
        int   ex, ey, n, vcount, vat, a1, a2;
        logic bok;
        int   rx [4] = '{0, 1177060, 1264088, 342923};
        int   ry [4] = '{32'h0019_6666, 1177060, 1009817, 1522571};

        bus.start = 1'b0;
        bus.xita1 = '0;
        bus.xita2 = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_valid", bus.valid, 1'b0);
        check_eq("rst_x", bus.x, 32'd0);
        check_eq("rst_y", bus.y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arm poses, including the angle-sum wrap cases.
        run("hpi_0", HPI, 0, 0, 32'h0019_6666, 64);
        run("0_hpi", 0, HPI, 32'h0007_6666, 32'h0012_0000, 64);
        run("hpi_mhpi", HPI, -HPI, 32'h0012_0000, 32'h0007_6666, 64);
        run("pi_hpi", PI, HPI, -32'sh0007_6666, -32'sh0012_0000, 64);
        run("mpi_mhpi", -PI, -HPI, -32'sh0007_6666, 32'h0012_0000, 64);
        run_model("zero", 0, 0);
        run_model("neg_pi_both", -PI, -PI);

        // Random poses across the full legal range.
        for (int k = 0; k < 8; k++) begin
            a1 = int'($urandom_range(2 * PI)) - PI;
            a2 = int'($urandom_range(2 * PI)) - PI;
            run_model($sformatf("rand%0d", k), a1, a2);
        end

        // Starts while busy are ignored; only the first request completes.
        fk(HPI / 2, HPI / 3, ex, ey);
        issue(HPI / 2, HPI / 3);
        vcount = 0;
        vat    = 0;
        bok    = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 5 || c == 20) begin
                bus.start = 1'b1;
                bus.xita1 = -PI / 2;
                bus.xita2 = PI / 4;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.valid) begin
                vcount++;
                vat = c;
            end
            if (c < 35 && !bus.busy) bok = 1'b0;
        end
        bus.start = 1'b0;
        check_eq("hs_valid_count", vcount, 1);
        check_eq("hs_valid_cycle", vat, 35);
        check_eq("hs_busy", bok, 1'b1);
        check_tol("hs_x", bus.x, ex, 64);
        check_tol("hs_y", bus.y, ey, 64);

        // Back-to-back: request issued in the valid cycle is accepted.
        fk(-HPI, HPI / 2, ex, ey);
        issue(HPI, 0);
        wait_valid(n, bok);
        check_eq("b2b_first_latency", n, 35);
        issue(-HPI, HPI / 2);
        wait_valid(n, bok);
        check_eq("b2b_second_latency", n, 35);
        check_tol("b2b_x", bus.x, ex, 64);
        check_tol("b2b_y", bus.y, ey, 64);

        // Mid-operation reset aborts with no valid pulse.
        issue(PI / 3, PI / 5);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", bus.busy, 1'b0);
        check_eq("abort_valid", bus.valid, 1'b0);
        check_eq("abort_x", bus.x, 32'd0);
        check_eq("abort_y", bus.y, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        vcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid) vcount++;
        end
        check_eq("abort_no_valid", vcount, 0);
        run_model("after_abort", PI / 3, PI / 5);

        // Round trip through analytic inverse kinematics.
        for (int k = 0; k < 4; k++) begin
            ik(rx[k], ry[k], a1, a2);
            run($sformatf("round%0d", k), a1, a2, rx[k], ry[k], 128);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
